// File: rtl/trig_in_pkg.sv
// Shared types and default sizing for the trigger input capture block.
package trig_in_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PULSE = 2'd2,
    ST_DONE  = 2'd3
  } trig_state_e;

  localparam int DEL_W_DEFAULT     = 21;
  localparam int DUR_W_DEFAULT     = 11;
  localparam int MIN_WIDTH_DEFAULT = 4;

  localparam int DEL_SAT_DEFAULT = (1 << DEL_W_DEFAULT) - 1;
  localparam int DUR_SAT_DEFAULT = (1 << DUR_W_DEFAULT) - 1;

endpackage

// File: rtl/trig_in_sync.sv
// Two-flop synchronizer for trig_in plus one edge register; level and edges
// are reported relative to rest_level.
module trig_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic trig_in,
  input  logic rest_level,
  output logic level_active,
  output logic rise,
  output logic fall
);

  logic sync1_q;
  logic sync2_q;
  logic edge_q;
  logic prev_active;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= rest_level;
      sync2_q <= rest_level;
      edge_q  <= rest_level;
    end else begin
      sync1_q <= trig_in;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign level_active = sync2_q ^ rest_level;
  assign prev_active  = edge_q ^ rest_level;
  assign rise         = level_active & ~prev_active;
  assign fall         = ~level_active & prev_active;

endmodule

// File: rtl/trigger_input_capture.sv
// Captures arm-to-edge delay and active pulse width of an asynchronous trigger.
// Define TRIG_IN_GLITCH_FILTER_EN to reject pulses shorter than MIN_WIDTH.
//
// state | meaning
// IDLE  | waiting for arm
// ARMED | counting delay, waiting for a rest-to-active edge
// PULSE | counting active width, delay counter keeps running
// DONE  | result_valid held until result_ack
module trigger_input_capture
  import trig_in_pkg::*;
#(
  parameter int DEL_W     = DEL_W_DEFAULT,
  parameter int DUR_W     = DUR_W_DEFAULT,
  parameter int MIN_WIDTH = MIN_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig_in,
  input  logic             rest_level,
  input  logic             arm,
  input  logic             hard_stop,
  input  logic             result_ack,
  output logic             busy,
  output logic             result_valid,
  output logic             timeout,
  output logic [DEL_W-1:0] delay_cycles,
  output logic [DUR_W-1:0] width_cycles
);

`ifdef TRIG_IN_GLITCH_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  localparam logic [DEL_W-1:0] DEL_SAT = '1;
  localparam logic [DUR_W-1:0] DUR_SAT = '1;
  localparam logic [DUR_W-1:0] MIN_W   = DUR_W'(MIN_WIDTH);

  trig_state_e      state_q;
  logic             busy_q;
  logic             valid_q;
  logic             timeout_q;
  logic [DEL_W-1:0] delay_cnt_q;
  logic [DEL_W-1:0] delay_cap_q;
  logic [DEL_W-1:0] delay_out_q;
  logic [DUR_W-1:0] width_cnt_q;
  logic [DUR_W-1:0] width_out_q;

  logic             level_active;
  logic             rise;
  logic             fall;
  logic [DEL_W-1:0] delay_cnt_d;
  logic [DUR_W-1:0] width_cnt_d;
  logic             short_pulse;

  trig_in_sync u_sync (
    .clk          (clk),
    .rst          (rst),
    .trig_in      (trig_in),
    .rest_level   (rest_level),
    .level_active (level_active),
    .rise         (rise),
    .fall         (fall)
  );

  assign delay_cnt_d = (delay_cnt_q == DEL_SAT) ? DEL_SAT : delay_cnt_q + DEL_W'(1);
  assign width_cnt_d = (width_cnt_q == DUR_SAT) ? DUR_SAT : width_cnt_q + DUR_W'(1);
  // With the filter compiled out this folds to 0 and MIN_WIDTH has no effect.
  assign short_pulse = FILTER_EN && (width_cnt_q < MIN_W);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      delay_cnt_q <= '0;
      delay_cap_q <= '0;
      delay_out_q <= '0;
      width_cnt_q <= '0;
      width_out_q <= '0;
    end else if (hard_stop) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      delay_cnt_q <= '0;
      delay_cap_q <= '0;
      delay_out_q <= '0;
      width_cnt_q <= '0;
      width_out_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_q     <= ST_ARMED;
            busy_q      <= 1'b1;
            delay_cnt_q <= '0;
          end
        end
        ST_ARMED: begin
          delay_cnt_q <= delay_cnt_d;
          if (rise) begin
            state_q     <= ST_PULSE;
            delay_cap_q <= delay_cnt_d;
            width_cnt_q <= DUR_W'(1);
          end else if (delay_cnt_d == DEL_SAT) begin
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            valid_q     <= 1'b1;
            timeout_q   <= 1'b1;
            delay_out_q <= DEL_SAT;
            width_out_q <= '0;
          end
        end
        ST_PULSE: begin
          delay_cnt_q <= delay_cnt_d;
          if (fall) begin
            if (short_pulse) begin
              state_q <= ST_ARMED;
            end else begin
              state_q     <= ST_DONE;
              busy_q      <= 1'b0;
              valid_q     <= 1'b1;
              timeout_q   <= 1'b0;
              delay_out_q <= delay_cap_q;
              width_out_q <= width_cnt_q;
            end
          end else if (level_active) begin
            width_cnt_q <= width_cnt_d;
          end
        end
        ST_DONE: begin
          if (result_ack) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign timeout      = timeout_q;
  assign delay_cycles = delay_out_q;
  assign width_cycles = width_out_q;

endmodule

// File: tb/tb_trigger_input_capture.sv
// Self-checking bench for trigger_input_capture against a timeline-based reference.
module tb_trigger_input_capture;

  localparam int DEL_W     = 8;
  localparam int DUR_W     = 11;
  localparam int MIN_WIDTH = 4;
  localparam int DEL_SAT   = (1 << DEL_W) - 1;
  localparam int DUR_SAT   = (1 << DUR_W) - 1;
`ifdef TRIG_IN_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             trig_in = 1'b0;
  logic             rest_level = 1'b0;
  logic             arm = 1'b0;
  logic             hard_stop = 1'b0;
  logic             result_ack = 1'b0;
  logic             busy;
  logic             result_valid;
  logic             timeout;
  logic [DEL_W-1:0] delay_cycles;
  logic [DUR_W-1:0] width_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  // act_q[k] = line active at the clock edge k cycles after the arm edge
  bit act_q[$];
  bit pre_act;

  always #5 clk = ~clk;

  trigger_input_capture #(
    .DEL_W     (DEL_W),
    .DUR_W     (DUR_W),
    .MIN_WIDTH (MIN_WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .trig_in      (trig_in),
    .rest_level   (rest_level),
    .arm          (arm),
    .hard_stop    (hard_stop),
    .result_ack   (result_ack),
    .busy         (busy),
    .result_valid (result_valid),
    .timeout      (timeout),
    .delay_cycles (delay_cycles),
    .width_cycles (width_cycles)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic t, input logic a, input logic ack, input logic hs);
    @(negedge clk);
    trig_in    = t;
    arm        = a;
    result_ack = ack;
    hard_stop  = hs;
    @(posedge clk);
    #1;
  endtask

  function automatic bit act_at(input int i);
    if (i < 0) return pre_act;
    if (i < act_q.size()) return act_q[i];
    return 1'b0;
  endfunction

  // Edge k acts on a rise when the line became active at k-2 (sync latency);
  // delay seen at edge k is min(k, DEL_SAT); a pulse active for w samples
  // ends at edge r+w.
  function automatic void model(output int de, output int dl, output int wd, output bit to);
    int k, lim, r, w;
    k  = 1;
    de = -1;
    dl = 0;
    wd = 0;
    to = 1'b0;
    while (de < 0) begin
      lim = (k > DEL_SAT) ? k : DEL_SAT;
      r   = -1;
      for (int j = k; j <= lim && r < 0; j++)
        if (act_at(j - 2) && !act_at(j - 3)) r = j;
      if (r < 0) begin
        de = lim; dl = DEL_SAT; wd = 0; to = 1'b1;
      end else begin
        w = 0;
        while (act_at(r - 2 + w)) w++;
        if (FILT && w < MIN_WIDTH) begin
          k = r + w + 1;
        end else begin
          de = r + w;
          dl = (r > DEL_SAT) ? DEL_SAT : r;
          wd = (w > DUR_SAT) ? DUR_SAT : w;
          to = 1'b0;
        end
      end
    end
  endfunction

  task automatic push_run(input bit v, input int n);
    for (int i = 0; i < n; i++) act_q.push_back(v);
  endtask

  task automatic run_capture(input string tag, input bit rl, input bit pre);
    int de, dl, wd, seen;
    bit to;
    rest_level = rl;
    pre_act    = pre;
    repeat (4) step(rl ^ pre, 1'b0, 1'b0, 1'b0);
    model(de, dl, wd, to);
    seen = -1;
    for (int k = 0; k <= de + 3 && seen < 0; k++) begin
      step(rl ^ act_at(k), k == 0, 1'b0, 1'b0);
      if (result_valid === 1'b1) seen = k;
    end
    check({tag, " done_edge"}, seen, de);
    check({tag, " delay"}, 32'(delay_cycles), dl);
    check({tag, " width"}, 32'(width_cycles), wd);
    check({tag, " timeout"}, 32'(timeout), 32'(to));
    check({tag, " busy_done"}, 32'(busy), 0);
    step(rl, 1'b1, 1'b0, 1'b0);
    check({tag, " arm_in_done_valid"}, 32'(result_valid), 1);
    check({tag, " arm_in_done_busy"}, 32'(busy), 0);
    step(rl, 1'b1, 1'b1, 1'b0);
    check({tag, " ack_valid"}, 32'(result_valid), 0);
    check({tag, " ack_delay_kept"}, 32'(delay_cycles), dl);
    check({tag, " ack_width_kept"}, 32'(width_cycles), wd);
    step(rl, 1'b0, 1'b0, 1'b0);
    check({tag, " no_rearm"}, 32'(busy), 0);
  endtask

  initial begin
    int rises;

    // reset state
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("rst busy", 32'(busy), 0);
    check("rst valid", 32'(result_valid), 0);
    check("rst timeout", 32'(timeout), 0);
    check("rst delay", 32'(delay_cycles), 0);
    check("rst width", 32'(width_cycles), 0);
    rst = 1'b1;

    // basic pulse: edge at cycle 100, 50 cycles wide
    act_q.delete(); push_run(1'b0, 100); push_run(1'b1, 50);
    run_capture("basic", 1'b0, 1'b0);
    check("basic delay_102", 32'(delay_cycles), 102);
    check("basic width_50", 32'(width_cycles), 50);

    // no edge: saturating timeout
    act_q.delete();
    run_capture("timeout", 1'b0, 1'b0);
    check("timeout delay_255", 32'(delay_cycles), 255);

    // hard_stop in PULSE, with result_ack ignored while ARMED
    rest_level = 1'b0;
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("hs armed_busy", 32'(busy), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("hs ack_ignored", 32'(busy), 1);
    repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("hs pulse_busy", 32'(busy), 1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("hs busy", 32'(busy), 0);
    check("hs valid", 32'(result_valid), 0);
    check("hs timeout", 32'(timeout), 0);
    rises = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (result_valid !== 1'b0) rises++;
    end
    check("hs no_valid", rises, 0);

    // glitch then real pulse
    act_q.delete(); push_run(1'b0, 20); push_run(1'b1, 2); push_run(1'b0, 8); push_run(1'b1, 10);
    run_capture("glitch", 1'b0, 1'b0);
    check("glitch width_expect", 32'(width_cycles), FILT ? 10 : 2);

    // width saturation
    act_q.delete(); push_run(1'b0, 10); push_run(1'b1, 3000);
    run_capture("widesat", 1'b0, 1'b0);
    check("widesat width_2047", 32'(width_cycles), 2047);

    // rest high, line already low at arm
    act_q.delete(); push_run(1'b1, 20); push_run(1'b0, 10); push_run(1'b1, 15);
    run_capture("preactive", 1'b1, 1'b1);
    check("preactive delay_32", 32'(delay_cycles), 32);

    // randomized timelines
    for (int n = 0; n < 8; n++) begin
      act_q.delete();
      if ($urandom_range(0, 1) == 1) push_run(1'b1, $urandom_range(1, 12));
      push_run(1'b0, $urandom_range(1, 60));
      if ($urandom_range(0, 1) == 1) begin
        push_run(1'b1, $urandom_range(1, 5));
        push_run(1'b0, $urandom_range(1, 20));
      end
      push_run(1'b1, $urandom_range(1, 80));
      run_capture($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // reset mid-capture overrides hard_stop, arm and ack
    rest_level = 1'b0;
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0; hard_stop = 1'b1; arm = 1'b1; result_ack = 1'b1;
    @(posedge clk);
    #1;
    check("midrst busy", 32'(busy), 0);
    check("midrst valid", 32'(result_valid), 0);
    check("midrst delay", 32'(delay_cycles), 0);
    check("midrst width", 32'(width_cycles), 0);
    rst = 1'b1;
    rises = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (result_valid !== 1'b0 || busy !== 1'b0) rises++;
    end
    check("midrst quiet", rises, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
